// File: rtl/can_rx_crc_check.sv
// Receive-side CAN CRC checker: strips stuff bits, recomputes the 16-bit CRC over the payload,
// captures the received CRC field and reports ok / crc error / stuff error with a one-cycle done pulse.
module can_rx_crc_check #(
  parameter int          DATA_BITS = 48,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF,
  parameter bit          STUFF_EN  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        bit_valid,
  input  logic        data,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        stuff_err,
  output logic [15:0] rx_crc,
  output logic [15:0] calc_crc
);

  localparam int CNT_W_RAW = $clog2(DATA_BITS + 1);
  localparam int CNT_W     = (CNT_W_RAW < 5) ? 5 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_CRC  = CNT_W'(16);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        r_q, r_d;
  logic [15:0]        rx_crc_q, rx_crc_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]         run_len_q, run_len_d;
  logic               last_bit_q, last_bit_d;
  logic               done_q, done_d;
  logic               crc_ok_q, crc_ok_d;
  logic               crc_err_q, crc_err_d;
  logic               stuff_err_q, stuff_err_d;
  logic               is_stuff;
  logic [15:0]        rx_crc_shift;

  // Bit-serial update; must stay bit-identical to the transmitter's generator.
  function automatic logic [15:0] crc_step(input logic [15:0] r, input logic d);
    logic fb;
    fb = r[15] ^ d;
    return {r[14] ^ d, r[13:2], r[1] ^ fb, r[0], fb};
  endfunction

  assign is_stuff     = STUFF_EN && (run_len_q == 3'd5);
  assign rx_crc_shift = {rx_crc_q[14:0], data};

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    rx_crc_d    = rx_crc_q;
    bit_cnt_d   = bit_cnt_q;
    run_len_d   = run_len_q;
    last_bit_d  = last_bit_q;
    done_d      = 1'b0;
    crc_ok_d    = crc_ok_q;
    crc_err_d   = crc_err_q;
    stuff_err_d = stuff_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          r_d         = CRC_INIT;
          rx_crc_d    = 16'h0000;
          bit_cnt_d   = CNT_DATA;
          run_len_d   = 3'd0;
          crc_ok_d    = 1'b0;
          crc_err_d   = 1'b0;
          stuff_err_d = 1'b0;
          state_d     = ST_DATA;
        end
      end

      ST_DATA, ST_CRC: begin
        if (bit_valid) begin
          if (is_stuff) begin
            // A sixth equal bit where a complement was required aborts the frame.
            if (data == last_bit_q) begin
              stuff_err_d = 1'b1;
              crc_ok_d    = 1'b0;
              crc_err_d   = 1'b0;
              done_d      = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              last_bit_d = data;
              run_len_d  = 3'd1;
            end
          end else begin
            run_len_d  = ((run_len_q != 3'd0) && (data == last_bit_q)) ? run_len_q + 3'd1 : 3'd1;
            last_bit_d = data;
            if (state_q == ST_DATA) begin
              r_d = crc_step(r_q, data);
              if (bit_cnt_q == CNT_ONE) begin
                bit_cnt_d = CNT_CRC;
                state_d   = ST_CRC;
              end else begin
                bit_cnt_d = bit_cnt_q - CNT_ONE;
              end
            end else begin
              rx_crc_d  = rx_crc_shift;
              bit_cnt_d = bit_cnt_q - CNT_ONE;
              if (bit_cnt_q == CNT_ONE) begin
                crc_ok_d  = (rx_crc_shift == r_q);
                crc_err_d = (rx_crc_shift != r_q);
                done_d    = 1'b1;
                state_d   = ST_IDLE;
              end
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      r_q         <= CRC_INIT;
      rx_crc_q    <= 16'h0000;
      bit_cnt_q   <= '0;
      run_len_q   <= 3'd0;
      last_bit_q  <= 1'b0;
      done_q      <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      rx_crc_q    <= rx_crc_d;
      bit_cnt_q   <= bit_cnt_d;
      run_len_q   <= run_len_d;
      last_bit_q  <= last_bit_d;
      done_q      <= done_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign crc_ok    = crc_ok_q;
  assign crc_err   = crc_err_q;
  assign stuff_err = stuff_err_q;
  assign rx_crc    = rx_crc_q;
  assign calc_crc  = r_q;

endmodule

// File: tb/tb_can_rx_crc_check.sv
// Randomized bench for can_rx_crc_check: one instance without stuffing, one with stuffing,
// driven from transmitter-side frame construction (payload CRC, then stuff-bit insertion).
module tb_can_rx_crc_check;

  logic        clock = 1'b0;
  logic        reset, start0, start1, bit_valid, data;
  logic        busy0, done0, ok0, err0, serr0;
  logic        busy1, done1, ok1, err1, serr1;
  logic [15:0] rx0, calc0, rx1, calc1;

  int checks   = 0;
  int failures = 0;
  int sel      = 0;
  bit line_q[$];

  logic        o_busy, o_done, o_ok, o_err, o_serr;
  logic [15:0] o_rx, o_calc;

  always #5 clock = ~clock;

  can_rx_crc_check #(.DATA_BITS(48), .CRC_INIT(16'hFFFF), .STUFF_EN(1'b0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .bit_valid(bit_valid), .data(data),
    .busy(busy0), .done(done0), .crc_ok(ok0), .crc_err(err0), .stuff_err(serr0),
    .rx_crc(rx0), .calc_crc(calc0));

  can_rx_crc_check #(.DATA_BITS(48), .CRC_INIT(16'hFFFF), .STUFF_EN(1'b1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .bit_valid(bit_valid), .data(data),
    .busy(busy1), .done(done1), .crc_ok(ok1), .crc_err(err1), .stuff_err(serr1),
    .rx_crc(rx1), .calc_crc(calc1));

  assign o_busy = (sel == 1) ? busy1 : busy0;
  assign o_done = (sel == 1) ? done1 : done0;
  assign o_ok   = (sel == 1) ? ok1   : ok0;
  assign o_err  = (sel == 1) ? err1  : err0;
  assign o_serr = (sel == 1) ? serr1 : serr0;
  assign o_rx   = (sel == 1) ? rx1   : rx0;
  assign o_calc = (sel == 1) ? calc1 : calc0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start0 = v;
    else            start1 = v;
  endtask

  // Golden payload CRC: init FFFF, MSB of payload first.
  function automatic logic [15:0] model_crc(input logic [47:0] pl);
    logic [15:0] r;
    logic        d, fb;
    r = 16'hFFFF;
    for (int i = 47; i >= 0; i--) begin
      d  = pl[i];
      fb = r[15] ^ d;
      r  = {r[14] ^ d, r[13:2], r[1] ^ fb, r[0], fb};
    end
    return r;
  endfunction

  // Serialises payload + CRC field and inserts a complement after every 5 equal line bits.
  task automatic build_line(input logic [47:0] pl, input logic [15:0] crc, input bit stuff);
    bit logical[64];
    int run;
    bit last, b;
    for (int i = 0; i < 48; i++) logical[i] = pl[47-i];
    for (int i = 0; i < 16; i++) logical[48+i] = crc[15-i];
    line_q.delete();
    run  = 0;
    last = 1'b0;
    for (int i = 0; i < 64; i++) begin
      b = logical[i];
      line_q.push_back(b);
      if (stuff) begin
        if (run > 0 && b == last) run++;
        else run = 1;
        last = b;
        if (run == 5 && i < 63) begin
          line_q.push_back(~b);
          last = ~b;
          run  = 1;
        end
      end
    end
  endtask

  // Start (with a stray strobe that must be ignored), then stream line_q; stops at the first done.
  task automatic run_frame(input int which, input int gap_max, input bit busy_starts, output int done_at);
    sel = which;
    set_start(which, 1'b1);
    bit_valid = 1'b1;
    data      = 1'($urandom);
    tick();
    set_start(which, 1'b0);
    bit_valid = 1'b0;
    done_at   = -1;
    for (int i = 0; i < line_q.size(); i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        if (busy_starts) set_start(which, 1'b1);
        tick();
        set_start(which, 1'b0);
      end
      bit_valid = 1'b1;
      data      = line_q[i];
      if (busy_starts && (i % 3 == 0)) set_start(which, 1'b1);
      tick();
      bit_valid = 1'b0;
      set_start(which, 1'b0);
      if (o_done) begin
        done_at = i + 1;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int done_at, input bit eok, input bit eerr,
                             input bit eserr, input logic [15:0] erx, input logic [15:0] ecalc);
    check_eq({tag, ".done_at"}, done_at, line_q.size());
    check_eq({tag, ".busy"}, o_busy, 0);
    check_eq({tag, ".flags"}, {o_ok, o_err, o_serr}, {eok, eerr, eserr});
    check_eq({tag, ".rx_crc"}, o_rx, erx);
    check_eq({tag, ".calc_crc"}, o_calc, ecalc);
  endtask

  initial begin
    logic [47:0] pl;
    logic [15:0] crc;
    int          da;

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; bit_valid = 1'b0; data = 1'b0;
    repeat (3) tick();
    check_eq("reset.flags0", {busy0, done0, ok0, err0, serr0}, 5'b0);
    check_eq("reset.flags1", {busy1, done1, ok1, err1, serr1}, 5'b0);
    check_eq("reset.calc", calc0, 16'hFFFF);
    check_eq("reset.rx", rx0, 16'h0000);
    reset = 1'b0;
    tick();

    // No stuffing: random good frames, back to back (start in the done cycle).
    for (int k = 0; k < 4; k++) begin
      pl  = {16'($urandom), $urandom()};
      crc = model_crc(pl);
      build_line(pl, crc, 1'b0);
      run_frame(0, 0, 1'b0, da);
      check_frame("plain_ok", da, 1'b1, 1'b0, 1'b0, crc, crc);
    end

    // Same frame with CRC bit 7 corrupted.
    build_line(pl, crc ^ 16'h0080, 1'b0);
    run_frame(0, 0, 1'b0, da);
    check_frame("crc_bit7", da, 1'b0, 1'b1, 1'b0, crc ^ 16'h0080, crc);
    tick();
    check_eq("done_one_cycle", o_done, 0);
    check_eq("err_held", o_err, 1);

    // Stuffed all-zero payload.
    crc = model_crc(48'h0);
    build_line(48'h0, crc, 1'b1);
    run_frame(1, 0, 1'b0, da);
    check_frame("stuff_zero", da, 1'b1, 1'b0, 1'b0, crc, crc);

    // Stuffed random frames with idle gaps and starts while busy.
    for (int k = 0; k < 3; k++) begin
      pl  = {16'($urandom), $urandom()};
      crc = model_crc(pl);
      build_line(pl, crc, 1'b1);
      run_frame(1, 7, 1'b1, da);
      check_frame("stuff_gaps", da, 1'b1, 1'b0, 1'b0, crc, crc);
    end

    // Six consecutive ones: violation on the sixth.
    line_q = '{1,0,1,0,1,0,1,0,1,0,1,1,1,1,1,1};
    run_frame(1, 3, 1'b0, da);
    check_eq("six_ones.done_at", da, 16);
    check_eq("six_ones.flags", {o_busy, o_ok, o_err, o_serr}, 4'b0001);
    check_eq("six_ones.rx", o_rx, 16'h0000);
    tick();
    check_eq("six_ones.held", {o_done, o_serr}, 2'b01);

    // Unstuffed frames with gaps and busy starts.
    for (int k = 0; k < 3; k++) begin
      pl  = {16'($urandom), $urandom()};
      crc = model_crc(pl);
      build_line(pl, crc, 1'b0);
      run_frame(0, 7, 1'b1, da);
      check_frame("plain_gaps", da, 1'b1, 1'b0, 1'b0, crc, crc);
    end

    // Reset after 20 payload bits, then a clean frame.
    pl  = {16'($urandom), $urandom()};
    crc = model_crc(pl);
    build_line(pl, crc, 1'b0);
    sel = 0;
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bit_valid = 1'b1;
      data      = line_q[i];
      tick();
    end
    bit_valid = 1'b0;
    check_eq("pre_reset.busy", o_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_reset.flags", {o_busy, o_done, o_ok, o_err, o_serr}, 5'b0);
    check_eq("mid_reset.calc", o_calc, 16'hFFFF);
    check_eq("mid_reset.rx", o_rx, 16'h0000);
    run_frame(0, 2, 1'b0, da);
    check_frame("after_reset", da, 1'b1, 1'b0, 1'b0, crc, crc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_rx_crc_check.md
Name: can_rx_crc_check

Overview:
- Receive-side counterpart of the transmit CRC generator.
- Consumes the serial CAN bitstream (MSB first) from the bit-timing/sampling stage, one bit per `bit_valid` strobe.
- Removes stuff bits and recomputes the 16-bit CRC over the payload. It then captures the received 16-bit CRC field, compares the two, and reports ok/error to the receive controller.

Parameters:
- DATA_BITS, 48, number of de-stuffed payload bits covered by the CRC.
- CRC_INIT, 16'hFFFF, CRC register value loaded on start.
- STUFF_EN, 1, 1 = detect and remove stuff bits after 5 equal bits; 0 = no stuffing.

Ports:
- clock  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame check (accepted only in IDLE).
- bit_valid  in  1  qualifies `data` for one cycle (sample strobe).
- data  in  1  received bus bit, MSB first.
- busy  out  1  high in DATA or CRC state.
- done  out  1  one-cycle pulse when a check finishes (ok, crc error, or stuff error).
- crc_ok  out  1  received CRC equals computed CRC; held until next start.
- crc_err  out  1  CRC mismatch; held until next start.
- stuff_err  out  1  stuffing violation; held until next start.
- rx_crc  out  16  received CRC field, shifted in MSB first.
- calc_crc  out  16  live CRC register r.

Behaviour:
- Reset: state=IDLE, r=CRC_INIT, rx_crc=0, counters=0. `busy`, `done`, `crc_ok`, `crc_err` and `stuff_err` are all 0.
- States: IDLE, DATA, CRC.
- IDLE + start:
  - r<=CRC_INIT, rx_crc<=0, bit_cnt<=DATA_BITS, run_len<=0.
  - Clear crc_ok/crc_err/stuff_err; go to DATA.
  - A bit_valid in the same cycle as start is ignored.
- IDLE without start: bit_valid ignored; start while busy is ignored.
- Stuff logic (STUFF_EN=1), evaluated on every bit_valid in DATA/CRC:
  - If run_len==5, the bit is a stuff bit.
  - If the stuff bit equals last_bit: stuff_err<=1, done pulse, crc_ok=crc_err=0, go to IDLE.
  - Otherwise discard it (no CRC update, no count), last_bit<=data, run_len<=1.
  - Non-stuff bits: run_len<=(data==last_bit)?run_len+1:1; last_bit<=data.
  - The first bit after start has run_len<=1.
  - Stuffing applies through the end of the CRC field.
- STUFF_EN=0: every valid bit is a payload/CRC bit.
- DATA, accepted payload bit d:
  - r[15]<=r[14]^d; r[14:3]<=r[13:2]; r[2]<=r[1]^r[15]^d; r[1]<=r[0]; r[0]<=r[15]^d.
  - These equations must match the transmitter bit-for-bit.
  - bit_cnt<=bit_cnt-1. On the bit where bit_cnt==1: bit_cnt<=16, go to CRC.
- CRC, accepted bit d:
  - rx_crc<={rx_crc[14:0],d}; r frozen; bit_cnt<=bit_cnt-1.
  - On the bit where bit_cnt==1, compare {rx_crc[14:0],d} against r.
  - Equal: crc_ok<=1. Else: crc_err<=1.
  - done pulse in the following cycle (registered); go to IDLE.
- Latency: done asserts exactly 1 clock after the final accepted CRC bit's bit_valid.
- Exactly one of crc_ok/crc_err/stuff_err is set per completed frame.
- bit_cnt width: $clog2(DATA_BITS+1), minimum 5 bits to hold 16.
- Gaps between bit_valid strobes of any length: state holds.
- Reset mid-frame: immediate return to the reset values; partial results discarded.
- New start is accepted in the cycle done is high (state is already IDLE).

Test Plan:
- STUFF_EN=0, 48 random bits followed by the golden-model CRC (bit-exact C model of the update equations, init FFFF) -> done after 64 valid bits, crc_ok=1, rx_crc==calc_crc.
- Same frame with CRC bit 7 flipped -> crc_err=1, crc_ok=0, rx_crc differs from calc_crc only at bit 7.
- STUFF_EN=1, payload 0x000000000000 with correct stuff bits (a 1 inserted after each 5 zeros) plus its CRC -> stuff bits discarded, crc_ok=1.
- STUFF_EN=1, six consecutive 1s in the payload -> stuff_err=1 on the 6th bit, done pulse, state IDLE, crc_ok=crc_err=0.
- bit_valid with 0-7 idle cycles between strobes, plus start asserted while busy -> result identical to back-to-back frame; the second start is ignored.
- reset asserted after 20 payload bits, then a fresh start and a valid frame -> all outputs 0 after reset, then crc_ok=1.
